// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module   : cpu_types_pkg
// Brief    : Shared CPU types: request-sequencer state and latched memory op.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DATA  = 2'd1,
        HALT  = 2'd2,
        ERROR = 2'd3
    } reqseq_state_t;

    typedef enum logic {
        MEM_RD = 1'b0,
        MEM_WR = 1'b1
    } memop_t;

    // A store wins when the decoder flags both load and store.
    function automatic memop_t decode_memop(input logic wen);
        return wen ? MEM_WR : MEM_RD;
    endfunction

endpackage

`default_nettype wire

// File: rtl/request_sequencer_if.sv
// ============================================================================
// Module   : request_sequencer_if
// Brief    : Bundle of control/cache handshake signals around request_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface request_sequencer_if #(
    parameter int CNT_W = 32
) (
    input logic CLK,
    input logic RST
);

    logic             ihit;
    logic             dhit;
    logic             regwr;
    logic             dcuREN;
    logic             dcuWEN;
    logic             halt;
    logic             imemREN;
    logic             dmemREN;
    logic             dmemWEN;
    logic             pcEN;
    logic             wreq;
    logic             halted;
    logic             err;
    logic [CNT_W-1:0] instr_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport seq (
        input  CLK, RST, ihit, dhit, regwr, dcuREN, dcuWEN, halt,
        output imemREN, dmemREN, dmemWEN, pcEN, wreq, halted, err,
               instr_cnt, stall_cnt
    );

    modport ctrl (
        input  CLK, RST, imemREN, dmemREN, dmemWEN, pcEN, wreq, halted, err,
               instr_cnt, stall_cnt,
        output ihit, dhit, regwr, dcuREN, dcuWEN, halt
    );

endinterface

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Brief    : Saturating up-counter with synchronous clear, async reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/request_sequencer.sv
// ============================================================================
// Module   : request_sequencer
// Brief    : Fetch/data request FSM with halt, bounded-wait timeout and
//            optional performance counters (enabled by REQ_SEQ_PERF_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module request_sequencer
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32,
    parameter int WAIT_W  = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             regwr,
    input  logic             dcuREN,
    input  logic             dcuWEN,
    input  logic             halt,
    output logic             imemREN,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic             pcEN,
    output logic             wreq,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [WAIT_W-1:0] c_timeout_last =
        WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    reqseq_state_t     r_state;
    reqseq_state_t     w_next;
    memop_t            r_op;
    memop_t            w_op_next;
    logic [WAIT_W-1:0] r_wait;
    logic              w_hit;
    logic              w_stall;
    logic              w_timeout;
    logic              w_pcen;
    logic              w_wreq;

    assign w_timeout = (TIMEOUT != 0) && (r_wait == c_timeout_last);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= FETCH;
            r_op    <= MEM_RD;
        end else begin
            r_state <= w_next;
            r_op    <= w_op_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_op_next = r_op;
        w_hit     = 1'b0;
        w_stall   = 1'b0;
        w_pcen    = 1'b0;
        w_wreq    = 1'b0;
        case (r_state)
            FETCH: begin
                if (ihit) begin
                    w_hit = 1'b1;
                    if (halt) begin
                        w_next = HALT;
                    end else if (dcuREN || dcuWEN) begin
                        w_next    = DATA;
                        w_op_next = decode_memop(dcuWEN);
                    end else begin
                        w_pcen = 1'b1;
                        w_wreq = regwr;
                    end
                end else begin
                    w_stall = 1'b1;
                    if (w_timeout) begin
                        w_next = ERROR;
                    end
                end
            end
            DATA: begin
                if (dhit) begin
                    w_hit  = 1'b1;
                    w_pcen = 1'b1;
                    w_wreq = regwr && (r_op == MEM_RD);
                    w_next = FETCH;
                end else begin
                    w_stall = 1'b1;
                    if (w_timeout) begin
                        w_next = ERROR;
                    end
                end
            end
            HALT:    w_next = HALT;
            ERROR:   w_next = ERROR;
            default: w_next = ERROR;
        endcase
    end

    // Every entry into FETCH/DATA goes through an accepted hit or reset,
    // so clearing on hit also covers clearing on state entry.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wait <= '0;
        end else if (w_hit) begin
            r_wait <= '0;
        end else if (w_stall) begin
            r_wait <= r_wait + WAIT_W'(1);
        end
    end

    assign imemREN = (r_state == FETCH);
    assign dmemREN = (r_state == DATA) && (r_op == MEM_RD);
    assign dmemWEN = (r_state == DATA) && (r_op == MEM_WR);
    assign halted  = (r_state == HALT);
    assign err     = (r_state == ERROR);

    // Mealy strobes are masked by reset so an aborted access emits nothing.
    assign pcEN = w_pcen && !RST;
    assign wreq = w_wreq && !RST;

`ifdef REQ_SEQ_PERF_EN
    sat_counter #(
        .WIDTH   (CNT_W)
    ) u_instr_cnt (
        .clk     (CLK),
        .rst     (RST),
        .i_clear (1'b0),
        .i_inc   (pcEN),
        .o_count (instr_cnt)
    );

    sat_counter #(
        .WIDTH   (CNT_W)
    ) u_stall_cnt (
        .clk     (CLK),
        .rst     (RST),
        .i_clear (1'b0),
        .i_inc   (w_stall),
        .o_count (stall_cnt)
    );
`else
    assign instr_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_request_sequencer.sv
// ============================================================================
// Module   : tb_request_sequencer
// Brief    : Directed self-checking bench for request_sequencer (TIMEOUT=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_request_sequencer;

    localparam int CNT_W = 32;
`ifdef REQ_SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             ihit = 1'b0, dhit = 1'b0, regwr = 1'b0;
    logic             dcuREN = 1'b0, dcuWEN = 1'b0, halt = 1'b0;
    logic             imemREN, dmemREN, dmemWEN, pcEN, wreq, halted, err;
    logic [CNT_W-1:0] instr_cnt, stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    request_sequencer #(
        .TIMEOUT   (8),
        .CNT_W     (CNT_W),
        .WAIT_W    (16)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .ihit      (ihit),
        .dhit      (dhit),
        .regwr     (regwr),
        .dcuREN    (dcuREN),
        .dcuWEN    (dcuWEN),
        .halt      (halt),
        .imemREN   (imemREN),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .pcEN      (pcEN),
        .wreq      (wreq),
        .halted    (halted),
        .err       (err),
        .instr_cnt (instr_cnt),
        .stall_cnt (stall_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic i, input logic d, input logic rw,
                         input logic ren, input logic wen, input logic h);
        @(negedge CLK);
        RST = 1'b0; ihit = i; dhit = d; regwr = rw;
        dcuREN = ren; dcuWEN = wen; halt = h;
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; ihit = 0; dhit = 0; regwr = 0; dcuREN = 0; dcuWEN = 0; halt = 0;
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // Reset state with ihit already high: strobes must stay masked.
        ihit = 1'b1; regwr = 1'b1;
        #1;
        check("rst_imemREN", imemREN, 1);
        check("rst_pcEN", pcEN, 0);
        check("rst_wreq", wreq, 0);
        check("rst_dmem", {dmemREN, dmemWEN}, 0);
        check("rst_flags", {halted, err}, 0);
        check("rst_instr_cnt", instr_cnt, 0);
        @(negedge CLK);

        // Back-to-back zero-wait ALU instructions.
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 1, 0, 0, 0);
            check("alu_pcEN", pcEN, 1);
            check("alu_wreq", wreq, 1);
            check("alu_imemREN", imemREN, 1);
        end
        drive(0, 0, 0, 0, 0, 0);
        check("alu_instr_cnt", instr_cnt, PERF ? 3 : 0);
        check("alu_stall_pcEN", pcEN, 0);

        // Load with 4 wait cycles on the data side.
        do_reset();
        drive(1, 0, 1, 1, 0, 0);
        check("ld_fetch_pcEN", pcEN, 0);
        check("ld_fetch_wreq", wreq, 0);
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 1, 0, 0, 0);
            check("ld_wait_req", {imemREN, dmemREN, dmemWEN}, 3'b010);
            check("ld_wait_pcEN", pcEN, 0);
        end
        drive(0, 1, 1, 0, 0, 0);
        check("ld_hit_pcEN", pcEN, 1);
        check("ld_hit_wreq", wreq, 1);
        drive(0, 0, 0, 0, 0, 0);
        check("ld_back_fetch", {imemREN, dmemREN}, 2'b10);
        check("ld_stall_cnt", stall_cnt, PERF ? 4 : 0);
        check("ld_instr_cnt", instr_cnt, PERF ? 1 : 0);

        // Store (both load/store flags set); ihit during DATA is ignored.
        do_reset();
        drive(1, 0, 1, 1, 1, 0);
        check("st_fetch_pcEN", pcEN, 0);
        drive(1, 0, 1, 0, 0, 0);
        check("st_wait_req", {imemREN, dmemREN, dmemWEN}, 3'b001);
        check("st_ihit_ignored", pcEN, 0);
        drive(0, 1, 1, 0, 0, 0);
        check("st_hit_pcEN", pcEN, 1);
        check("st_hit_wreq", wreq, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("st_back_fetch", imemREN, 1);

        // Timeout: 8 cycles without ihit, error visible from cycle 9.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(0, 1, 0, 0, 0, 0);
        end
        check("to_cycle8_err", err, 0);
        drive(1, 1, 1, 0, 0, 0);
        check("to_err", err, 1);
        check("to_reqs", {imemREN, dmemREN, dmemWEN}, 0);
        check("to_strobes", {pcEN, wreq}, 0);
        check("to_stall_cnt", stall_cnt, PERF ? 8 : 0);
        drive(1, 1, 1, 0, 0, 0);
        check("to_sticky", {err, halted}, 2'b10);

        // Hit on the timeout cycle wins.
        do_reset();
        for (int k = 0; k < 7; k++) begin
            drive(0, 0, 0, 0, 0, 0);
        end
        drive(1, 0, 0, 0, 0, 0);
        check("to_edge_pcEN", pcEN, 1);
        check("to_edge_wreq", wreq, 0);
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 0, 0);
        end
        check("to_edge_no_err", err, 0);
        check("to_edge_fetch", imemREN, 1);

        // Halt is sticky and ignores later hits.
        do_reset();
        drive(1, 0, 1, 0, 0, 1);
        check("hlt_pcEN", pcEN, 0);
        check("hlt_wreq", wreq, 0);
        for (int k = 0; k < 10; k++) begin
            drive(1, 1, 1, 1, 0, 0);
        end
        check("hlt_halted", halted, 1);
        check("hlt_reqs", {imemREN, dmemREN, dmemWEN}, 0);
        check("hlt_strobes", {pcEN, wreq}, 0);
        check("hlt_no_err", err, 0);

        // Asynchronous reset in the middle of a data access.
        do_reset();
        drive(1, 0, 1, 1, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        check("ar_in_data", dmemREN, 1);
        dhit = 1'b1; RST = 1'b1;
        #1;
        check("ar_imemREN", imemREN, 1);
        check("ar_dmem", {dmemREN, dmemWEN}, 0);
        check("ar_strobes", {pcEN, wreq}, 0);
        check("ar_flags", {halted, err}, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("ar_after_release", {imemREN, dmemREN, pcEN}, 3'b100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
